// File: rtl/oled_string_streamer.sv
// Byte streamer for the oledControl handshake: sends a snapshot of a character string,
// optionally space-padded to a full frame, on a start pulse or when the string changes.
module oled_string_streamer #(
  parameter int         MAX_CHARS    = 64,
  parameter bit         PAD_EN       = 1'b1,
  parameter logic [7:0] PAD_CHAR     = 8'h20,
  parameter bit         AUTO_REFRESH = 1'b1,
  parameter int         LEN_W        = $clog2(MAX_CHARS + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [MAX_CHARS*8-1:0] i_str_data,
  input  logic [LEN_W-1:0]       i_str_len,
  input  logic                   i_start,
  output logic [7:0]             o_send_data,
  output logic                   o_send_valid,
  input  logic                   i_send_done,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SEND, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);

  state_t                 r_state;
  logic [LEN_W-1:0]       r_idx;
  logic [LEN_W-1:0]       r_snap_len;
  logic [MAX_CHARS*8-1:0] r_snap_data;
  logic [7:0]             r_send_data;
  logic                   r_send_valid;
  logic                   r_busy;
  logic                   r_frame_done;

  logic [LEN_W-1:0] w_len_clamp;
  logic [LEN_W-1:0] w_nbytes;
  logic             w_changed;
  logic             w_trigger;
  logic             w_last;
  logic [7:0]       w_char;
  logic [7:0]       w_byte;

  assign w_len_clamp = (i_str_len > MAX_LEN) ? MAX_LEN : i_str_len;
  assign w_changed   = (i_str_data != r_snap_data) || (w_len_clamp != r_snap_len);
  assign w_trigger   = i_start || (AUTO_REFRESH && w_changed);
  assign w_nbytes    = PAD_EN ? MAX_LEN : r_snap_len;
  assign w_last      = (r_idx == w_nbytes - LEN_W'(1));

  // Char 0 lives in the most significant byte of the string bus.
  always_comb begin
    w_char = 8'h00;
    for (int k = 0; k < MAX_CHARS; k++) begin
      if (r_idx == LEN_W'(k)) w_char = r_snap_data[(MAX_CHARS-k)*8-1 -: 8];
    end
  end

  assign w_byte = (r_idx < r_snap_len) ? w_char : PAD_CHAR;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_snap_len   <= '0;
      r_snap_data  <= '0;
      r_send_data  <= 8'h00;
      r_send_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_snap_data <= i_str_data;
            r_snap_len  <= w_len_clamp;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_nbytes == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else if (!i_send_done) begin
            // A done still high here belongs to the previous byte; wait it out.
            r_send_data  <= w_byte;
            r_send_valid <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_send_done) begin
            r_send_valid <= 1'b0;
            r_idx        <= r_idx + LEN_W'(1);
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_send_data  = r_send_data;
  assign o_send_valid = r_send_valid;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_oled_string_streamer.sv
// Bench for oled_string_streamer: a padded/auto-refresh instance and an unpadded/manual one,
// each driven by an oledControl responder model; bytes are checked against an expected queue.
module tb_oled_string_streamer;
  localparam int MC = 64;
  localparam int LW = $clog2(MC + 1);

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [MC*8-1:0] sdat [2];
  logic [LW-1:0]   slen [2];
  logic            st   [2];
  logic [7:0]      sd   [2];
  logic            sv   [2];
  logic            sdn  [2] = '{1'b0, 1'b0};
  logic            bz   [2];
  logic            fd   [2];

  int         hold [2] = '{0, 0};
  int         ncap [2] = '{0, 0};
  int         nfd  [2] = '{0, 0};
  int         viol [2] = '{0, 0};
  int         hc   [2] = '{0, 0};
  int         rd   [2] = '{0, 0};
  logic       pv   [2] = '{1'b0, 1'b0};
  logic [7:0] psd  [2];
  logic [7:0] cap  [2][0:1023];
  logic [7:0] exq  [$];

  oled_string_streamer #(.MAX_CHARS(MC), .PAD_EN(1'b1), .PAD_CHAR(8'h20), .AUTO_REFRESH(1'b1)) u_a (
    .i_clock(clk), .i_reset(rst), .i_str_data(sdat[0]), .i_str_len(slen[0]), .i_start(st[0]),
    .o_send_data(sd[0]), .o_send_valid(sv[0]), .i_send_done(sdn[0]), .o_busy(bz[0]),
    .o_frame_done(fd[0]));

  oled_string_streamer #(.MAX_CHARS(MC), .PAD_EN(1'b0), .PAD_CHAR(8'h20), .AUTO_REFRESH(1'b0)) u_b (
    .i_clock(clk), .i_reset(rst), .i_str_data(sdat[1]), .i_str_len(slen[1]), .i_start(st[1]),
    .o_send_data(sd[1]), .o_send_valid(sv[1]), .i_send_done(sdn[1]), .o_busy(bz[1]),
    .o_frame_done(fd[1]));

  // oledControl model: raise done after a new valid, hold it hold[d]+1 cycles, record bytes.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sdn[d] = 1'b0;
        hc[d]  = 0;
        pv[d]  = 1'b0;
      end else begin
        if (sv[d] && !pv[d]) begin
          if (sdn[d]) viol[d]++;
          if (ncap[d] < 1024) cap[d][ncap[d]] = sd[d];
          ncap[d]++;
        end else if (sv[d] && sd[d] !== psd[d]) begin
          viol[d]++;
        end
        if (fd[d]) nfd[d]++;
        pv[d]  = sv[d];
        psd[d] = sd[d];
        if (sdn[d]) begin
          if (hc[d] >= hold[d]) begin
            sdn[d] = 1'b0;
            hc[d]  = 0;
          end else begin
            hc[d]++;
          end
        end else if (sv[d]) begin
          sdn[d] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [MC*8-1:0] mk(input string s);
    logic [MC*8-1:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < MC; i++) r[(MC-i)*8-1 -: 8] = s[i];
    return r;
  endfunction

  task automatic push_frame(input string s, input int len, input int n);
    for (int i = 0; i < n; i++) exq.push_back((i < len) ? s[i] : 8'h20);
  endtask

  task automatic drain(input int d, input string tag);
    logic [7:0] e;
    while (exq.size() > 0) begin
      e = exq.pop_front();
      check(tag, (rd[d] < ncap[d]) ? int'(cap[d][rd[d]]) : -1, int'(e));
      rd[d]++;
    end
    check({tag, "_count"}, ncap[d], rd[d]);
    rd[d] = ncap[d];
  endtask

  task automatic wait_fd(input int d, input int target, input int budget, input string tag);
    int n = 0;
    while (nfd[d] < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_frame_done"}, nfd[d], target);
  endtask

  task automatic wait_cap(input int d, input int target, input int budget, input string tag);
    int n = 0;
    while (ncap[d] < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_bytes_seen"}, ncap[d], target);
  endtask

  task automatic drv_edge();
    @(negedge clk); #2;
  endtask

  initial begin
    int base;
    logic [MC*8-1:0] pat;
    logic [7:0] b;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sdat[d] = '0; slen[d] = '0; st[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", int'(sv[d]), 0);
      check("rst_data",  int'(sd[d]), 0);
      check("rst_busy",  int'(bz[d]), 0);
      check("rst_fdone", int'(fd[d]), 0);
    end
    drv_edge(); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("empty_no_auto", ncap[0], 0);

    // 1: padded frame, start coinciding with an auto-trigger, plus start-to-valid latency
    drv_edge();
    sdat[0] = mk("PASS"); slen[0] = LW'(4); st[0] = 1'b1;
    push_frame("PASS", 4, 64);
    @(posedge clk); #1;
    check("t1_lat_busy", int'(bz[0]), 1);
    check("t1_lat_novalid", int'(sv[0]), 0);
    st[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_lat_valid", int'(sv[0]), 1);
    check("t1_lat_data", int'(sd[0]), 32'h50);
    wait_fd(0, 1, 2000, "t1");
    repeat (5) @(posedge clk);
    #1;
    check("t1_single_frame", nfd[0], 1);
    check("t1_busy_after", int'(bz[0]), 0);
    drain(0, "t1_byte");

    // 2: unpadded short string, then an empty string
    drv_edge();
    sdat[1] = mk("ABC"); slen[1] = LW'(3); st[1] = 1'b1;
    push_frame("ABC", 3, 3);
    @(posedge clk); #1; st[1] = 1'b0;
    wait_fd(1, 1, 500, "t2");
    repeat (3) @(posedge clk);
    drain(1, "t2_byte");
    base = ncap[1];
    drv_edge();
    slen[1] = '0; st[1] = 1'b1;
    @(posedge clk); #1; st[1] = 1'b0;
    check("t2z_busy", int'(bz[1]), 1);
    check("t2z_fd_early", int'(fd[1]), 0);
    @(posedge clk); #1;
    check("t2z_fd", int'(fd[1]), 1);
    check("t2z_novalid", int'(sv[1]), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t2z_no_bytes", ncap[1], base);
    check("t2z_frames", nfd[1], 2);

    // 3: over-length str_len clamps to a full frame
    for (int k = 0; k < MC; k++) begin
      b = 8'h40 + 8'(k);
      pat[(MC-k)*8-1 -: 8] = b;
      exq.push_back(b);
    end
    drv_edge();
    sdat[1] = pat; slen[1] = LW'(100); st[1] = 1'b1;
    @(posedge clk); #1; st[1] = 1'b0;
    wait_fd(1, 3, 2000, "t3");
    repeat (3) @(posedge clk);
    drain(1, "t3_byte");

    // 4: string change mid-frame; auto instance re-sends, manual instance does not
    drv_edge();
    sdat[0] = mk("OLD1"); slen[0] = LW'(4);
    push_frame("OLD1", 4, 64);
    wait_cap(0, rd[0] + 5, 200, "t4a");
    drv_edge();
    sdat[0] = mk("NEW22"); slen[0] = LW'(5);
    push_frame("NEW22", 5, 64);
    wait_fd(0, 3, 4000, "t4a");
    repeat (5) @(posedge clk);
    #1;
    check("t4a_two_frames", nfd[0], 3);
    drain(0, "t4a_byte");
    drv_edge();
    sdat[1] = mk("XY"); slen[1] = LW'(2); st[1] = 1'b1;
    push_frame("XY", 2, 2);
    @(posedge clk); #1; st[1] = 1'b0;
    wait_cap(1, rd[1] + 1, 200, "t4b");
    drv_edge();
    sdat[1] = mk("QQQ"); slen[1] = LW'(3);
    wait_fd(1, 4, 500, "t4b");
    repeat (30) @(posedge clk);
    #1;
    check("t4b_no_refresh", nfd[1], 4);
    drain(1, "t4b_byte");

    // 5: responder holds done high for several cycles per byte
    hold[0] = 5;
    drv_edge();
    sdat[0] = mk("HOLD"); slen[0] = LW'(4);
    push_frame("HOLD", 4, 64);
    wait_fd(0, 4, 5000, "t5");
    repeat (10) @(posedge clk);
    drain(0, "t5_byte");
    check("t5_protocol", viol[0], 0);
    hold[0] = 0;

    // 6: reset during byte 10, then the auto-refresh restarts from char 0
    drv_edge();
    sdat[0] = mk("RESET"); slen[0] = LW'(5);
    push_frame("RESET", 5, 11);
    wait_cap(0, rd[0] + 11, 500, "t6");
    rst = 1'b1;
    #1;
    check("t6_valid_drop", int'(sv[0]), 0);
    check("t6_busy_drop", int'(bz[0]), 0);
    repeat (3) @(posedge clk);
    drv_edge(); rst = 1'b0;
    drain(0, "t6_partial");
    push_frame("RESET", 5, 64);
    wait_fd(0, 5, 2000, "t6");
    repeat (5) @(posedge clk);
    #1;
    check("t6_frames", nfd[0], 5);
    drain(0, "t6_byte");
    check("proto_a", viol[0], 0);
    check("proto_b", viol[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
